// File: rtl/seven_seg_scan_reader_pkg.sv
// Shared definitions for the seven-segment scan reader: glyph table,
// blank pattern and FSM state encoding.
package seven_seg_scan_reader_pkg;

   // Segment patterns are written a..g left to right, active low, and
   // stored in [0:6] vectors so that bit 0 is segment a.
   localparam logic [0:6] SEG_BLANK = 7'b111_1111;

   // Hex glyph table, indexed by value. Both the display decoder and
   // this reader derive from this table so they cannot drift apart.
   localparam logic [0:6] GLYPH [16] = '{
      7'b000_0001,   // 0
      7'b100_1111,   // 1
      7'b001_0010,   // 2
      7'b000_0110,   // 3
      7'b100_1100,   // 4
      7'b010_0100,   // 5
      7'b010_0000,   // 6
      7'b000_1111,   // 7
      7'b000_0000,   // 8
      7'b000_0100,   // 9
      7'b000_1000,   // A
      7'b110_0000,   // B
      7'b011_0001,   // C
      7'b100_0010,   // D
      7'b011_0000,   // E
      7'b011_1000    // F
   };

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_t;

endpackage

// File: rtl/seven_seg_scan_reader_glyph_match.sv
// Combinational inverse of the hex-to-segment decoder: looks the
// segment pattern up in the shared glyph table.
module seven_seg_glyph_match
   import seven_seg_scan_reader_pkg::*;
(
   input  logic [0:6] seg,
   output logic       match,
   output logic [3:0] value,
   output logic       blank
);

   // Table search; glyphs are unique so at most one entry hits.
   always_comb begin
      match = 1'b0;
      value = 4'd0;
      blank = (seg == SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (seg == GLYPH[i]) begin
            match = 1'b1;
            value = 4'(i);
         end
      end
   end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Passive monitor for a multiplexed active-low seven-segment bus.
// Waits for each anode dwell to settle, samples the segment pattern
// once per dwell and keeps the decoded hex value per digit.
module seven_seg_scan_reader
   import seven_seg_scan_reader_pkg::*;
#(
   parameter  int NUM_DIGITS    = 4,
   parameter  int STABLE_CYCLES = 16,
   localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_DIGITS-1:0]   an,
   input  logic [0:6]              seg,
   output logic [4*NUM_DIGITS-1:0] digit_val,
   output logic [NUM_DIGITS-1:0]   digit_known,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic                    cap_strobe,
   output logic [IDX_W-1:0]        cap_idx,
   output logic                    multi_err
);

   localparam int              CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CYCLES - 1);

   // ---------------------------------------------------------------
   // Reset: asserts asynchronously, releases on a clock edge so no
   // register sees a release close to the edge.
   // ---------------------------------------------------------------
   logic [1:0] rst_pipe;
   logic       rst_i_n;

   // Two-flop reset release synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

   assign rst_i_n = rst_pipe[1];

   // ---------------------------------------------------------------
   // Input synchronisers and previous-sample registers. The bus idles
   // with everything off, so these reset to all ones.
   // ---------------------------------------------------------------
   logic [NUM_DIGITS-1:0] an_s1, an_s2, prev_an;
   logic [0:6]            seg_s1, seg_s2, prev_seg;

   // Double-flop the asynchronous bus and keep the prior synced sample.
   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         an_s1    <= '1;
         an_s2    <= '1;
         prev_an  <= '1;
         seg_s1   <= SEG_BLANK;
         seg_s2   <= SEG_BLANK;
         prev_seg <= SEG_BLANK;
      end else begin
         an_s1    <= an;
         an_s2    <= an_s1;
         prev_an  <= an_s2;
         seg_s1   <= seg;
         seg_s2   <= seg_s1;
         prev_seg <= seg_s2;
      end
   end

   logic changed;
   logic all_high;

   assign changed  = (an_s2 != prev_an) || (seg_s2 != prev_seg);
   assign all_high = &an_s2;

   // ---------------------------------------------------------------
   // Dwell FSM and stability counter
   // ---------------------------------------------------------------
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              do_cap;

   // State and counter registers.
   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. A change on the terminal cycle wins over the
   // capture, so a dwell is only sampled after a clean quiet window.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_cap  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!all_high) begin
               state_d = ST_SETTLE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_SETTLE: begin
            if (all_high) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (changed) begin
               cnt_d   = CNT_W'(1);
            end else if (cnt_q == TERM) begin
               state_d = ST_CAPTURE;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_CAPTURE: begin
            // The sample comes from prev_*, which still holds the settled
            // value. A change arriving this very cycle must not be lost,
            // otherwise the next dwell would sit in HOLD unnoticed.
            do_cap  = 1'b1;
            state_d = ST_HOLD;
            if (changed) begin
               state_d = all_high ? ST_IDLE : ST_SETTLE;
               cnt_d   = all_high ? '0 : CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (changed) begin
               state_d = all_high ? ST_IDLE : ST_SETTLE;
               cnt_d   = all_high ? '0 : CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Capture decode, taken from the settled sample
   // ---------------------------------------------------------------
   logic             g_match, g_blank;
   logic [3:0]       g_value;
   logic [IDX_W-1:0] low_idx;
   logic             one_low;
   logic             many_low;

   seven_seg_glyph_match u_match (
      .seg   (prev_seg),
      .match (g_match),
      .value (g_value),
      .blank (g_blank)
   );

   // Which anode is low, and how many.
   always_comb begin
      low_idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!prev_an[i]) low_idx = IDX_W'(i);
      end
      one_low  = ($countones(~prev_an) == 1);
      many_low = ($countones(~prev_an) > 1);
   end

   // ---------------------------------------------------------------
   // Per-digit result registers and capture outputs
   // ---------------------------------------------------------------
   // Update the addressed digit; an unknown or blank pattern leaves the
   // last good value in place.
   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         digit_val   <= '0;
         digit_known <= '0;
         digit_blank <= '1;
         cap_strobe  <= 1'b0;
         cap_idx     <= '0;
         multi_err   <= 1'b0;
      end else begin
         cap_strobe <= 1'b0;
         if (do_cap && one_low) begin
            cap_strobe           <= 1'b1;
            cap_idx              <= low_idx;
            digit_known[low_idx] <= g_match;
            digit_blank[low_idx] <= g_blank;
            if (g_match) digit_val[4*low_idx +: 4] <= g_value;
         end
         if (do_cap && many_low) multi_err <= 1'b1;
      end
   end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
- Passive monitor on a multiplexed, active-low seven-segment bus: anodes an[], segments seg[0:6] with a..g on bits 0..6.
- Waits for each anode dwell to settle, samples the segment pattern, and converts the glyph back to a 4-bit hex value per digit, so it is the inverse of the hex-to-segment decoder.
- Used by self-checking benches and on-board loopback to confirm what the display driver is actually showing.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines).
- STABLE_CYCLES, 16, consecutive clk cycles that an and seg must hold unchanged before a sample is taken (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- an  input  NUM_DIGITS  anode enables, active low, expected one-hot-low or all-high.
- seg  input  7 ([0:6])  segment lines a..g, active low.
- digit_val  output  4*NUM_DIGITS  decoded hex per digit; digit i occupies [4i+3:4i].
- digit_known  output  NUM_DIGITS  1 = last sample of digit i matched one of the 16 hex glyphs.
- digit_blank  output  NUM_DIGITS  1 = last sample of digit i was all-off (7'b111_1111).
- cap_strobe  output  1  one-cycle pulse when a digit is captured.
- cap_idx  output  $clog2(NUM_DIGITS)  index of the captured digit; valid while cap_strobe=1.
- multi_err  output  1  sticky; set when more than one anode is low during a full dwell.

Behaviour:
- Inputs are double-flop synchronised before any use; all timing below is counted from the synchronised values, which adds 2 cycles of latency.
- Reset (async assert, sync release) puts these registers at the values shown:
  - digit_val = 0, digit_known = 0, digit_blank = all 1.
  - cap_strobe = 0, cap_idx = 0, multi_err = 0, FSM = IDLE, stability counter = 0.
- Registered prev_an / prev_seg hold the previous synchronised sample. "Change" means either differs from its previous value.
- FSM:
  - IDLE: all anodes high. Go to SETTLE, counter = 1, on the first cycle with any anode low.
  - SETTLE: a change reloads counter = 1 and stays in SETTLE. All anodes high returns to IDLE. When counter = STABLE_CYCLES-1 with no change, go to CAPTURE. Otherwise counter increments.
  - CAPTURE: a single cycle.
    - Single-low anode k: update digit k, pulse cap_strobe with cap_idx = k.
    - Multiple lows: no digit update, no strobe, set multi_err.
    - Then go to HOLD.
  - HOLD: wait while inputs are unchanged. A change goes to SETTLE with counter = 1, or to IDLE if all anodes are high. This gives at most one capture per dwell.
- Glyph decode (segment pattern a..g -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->B
  - 0110001->C, 1000010->D, 0110000->E, 0111000->F
- Capture update:
  - Match: digit_val[k] = value, known = 1, blank = 0.
  - 1111111: digit_val[k] keeps its old value, known = 0, blank = 1.
  - Any other pattern: digit_val[k] keeps its old value, known = 0, blank = 0.
- A flash of the "0" glyph is indistinguishable from hex 0 and decodes as 0.
- A change on the same cycle the counter would reach terminal count takes priority, so no capture occurs.
- multi_err clears only on reset.
- Digits never captured keep their reset values.
- Reset mid-dwell aborts the dwell with no strobe. After release, a fresh STABLE_CYCLES of stability is required.

Decomposition:
- Shared package:
  - 16-entry glyph constant table (the single source of truth for both the decoder and this reader).
  - SEG_BLANK = 7'b111_1111.
  - FSM state encodings IDLE/SETTLE/CAPTURE/HOLD.
- Sub-module seven_seg_glyph_match: combinational seg -> {match, value[3:0], blank}, built from the package table.
- Top level holds the synchronisers, stability counter, FSM and per-digit registers.

Test Plan:
- Reset, then drive an=4'b1110 and seg=0010010 for 20 cycles:
  - one cap_strobe, cap_idx=0, cycle 2+STABLE_CYCLES±1 from the drive;
  - digit_val[3:0]=2, known[0]=1.
- Scan 4 digits at 32 cycles each showing F,0,7,B on digits 3..0:
  - digit_val=16'hF07B, digit_known=4'hF;
  - exactly 4 strobes per scan, cap_idx order 0,1,2,3.
- Hold an=1110 but toggle seg every 10 cycles: no cap_strobe ever, digit_val unchanged.
- Digit 1 shows 1111111, then 1111110 (unknown), 32 cycles each:
  - first dwell: blank[1]=1, known[1]=0;
  - second dwell: blank[1]=0, known[1]=0;
  - digit_val[7:4] retains its prior value in both.
- an=1100 for 32 cycles: multi_err=1 and stays 1, no strobe. A valid dwell afterwards still captures.
- Assert rst_n=0 at cycle 10 of a 20-cycle dwell, release at cycle 12:
  - no strobe from the aborted dwell;
  - outputs return to reset values;
  - the next stable dwell captures normally.
